// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multi-cycle control FSM
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8
  } state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_REG   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic IORD_PC     = 1'b0;
  localparam logic IORD_ALUOUT = 1'b1;

  localparam logic PCSRC_ALU    = 1'b0;
  localparam logic PCSRC_ALUOUT = 1'b1;

  // States that hold a request open to memory and may stall
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_stall_ctr.sv
// rtl/mem_stall_ctr.sv - saturating per-access memory wait counter with timeout pulse
module mem_stall_ctr #(
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic stall,
  output logic timeout
);

  localparam logic [7:0] CNT_MAX  = 8'(MEM_WAIT_MAX);
  localparam logic [7:0] CNT_LAST = 8'(MEM_WAIT_MAX - 1);

  logic [7:0] cnt;

  // Count stalled cycles, restart on each new access, hold at the limit
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= 8'd0;
    end else if (stall && (cnt != CNT_MAX)) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Pulse on the stalled cycle that brings the count up to the limit
  always_comb begin
    timeout = stall && !clr && !rst && (cnt == CNT_LAST);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM for the multi-cycle RV32 subset processor
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPW          = 7,
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_we,
  output logic           iord,
  output logic           ir_write,
  output logic           pc_en,
  output logic           pc_src,
  output logic [1:0]     alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic           reg_write,
  output logic           mem_to_reg,
  output logic           instr_done,
  output logic           illegal_op,
  output logic           mem_timeout,
  output logic [3:0]     state
);

  state_t state_q;
  state_t state_d;
  logic   stall;
  logic   stall_clr;
  logic   timeout_raw;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Wait counter restarts whenever the FSM moves to a different state
  assign stall     = !rst && is_mem_state(state_q) && !mem_ready;
  assign stall_clr = (state_d != state_q);

  mem_stall_ctr #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_stall_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr     (stall_clr),
    .stall   (stall),
    .timeout (timeout_raw)
  );

  // Next-state and output decode; everything held low while in reset
  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = IORD_PC;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_src      = PCSRC_ALU;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_REG;
    alu_op      = ALUOP_ADD;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    state       = 4'd0;

    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:   state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase

    if (!rst) begin
      state       = state_q;
      mem_timeout = timeout_raw;
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          iord      = IORD_PC;
          alu_src_a = SRC_A_PC;
          alu_src_b = SRC_B_FOUR;
          alu_op    = ALUOP_ADD;
          pc_src    = PCSRC_ALU;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
        end
        S_DECODE: begin
          alu_src_a  = SRC_A_OLDPC;
          alu_src_b  = SRC_B_IMM;
          alu_op     = ALUOP_ADD;
          illegal_op = !((opcode == OP_LW) || (opcode == OP_SW) ||
                         (opcode == OP_RTYPE) || (opcode == OP_BEQ));
        end
        S_MEM_ADDR: begin
          alu_src_a = SRC_A_REG;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALUOP_ADD;
        end
        S_MEM_READ: begin
          mem_req = 1'b1;
          iord    = IORD_ALUOUT;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          iord       = IORD_ALUOUT;
          instr_done = mem_ready;
        end
        S_EXECUTE: begin
          alu_src_a = SRC_A_REG;
          alu_src_b = SRC_B_REG;
          alu_op    = ALUOP_FUNCT;
        end
        S_ALU_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b0;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = SRC_A_REG;
          alu_src_b  = SRC_B_REG;
          alu_op     = ALUOP_SUB;
          pc_src     = PCSRC_ALUOUT;
          pc_en      = zero;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_en, pc_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic       reg_write, mem_to_reg, instr_done, illegal_op, mem_timeout;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.OPW(7), .MEM_WAIT_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .iord        (iord),
    .ir_write    (ir_write),
    .pc_en       (pc_en),
    .pc_src      (pc_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .mem_timeout (mem_timeout),
    .state       (state)
  );

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic        z;
    int          stall;
    int          cycles;
    logic [31:0] seq;
    int          seqn;
    int          regw;
    int          pcen;
    int          we;
    int          req;
    int          ill;
    int          done;
    int          tmo;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one instruction from its FETCH cycle until the FSM is back in FETCH.
  // Entered and left just after a falling edge with state at FETCH.
  task automatic run(input vec_t v);
    vec_t        e;
    int          waited = 0, cyc = 0, n = 0;
    int          regw = 0, pcen = 0, we = 0, req = 0, ill = 0, done = 0, tmo = 0;
    logic [31:0] seq = 32'h0;
    logic [3:0]  last = 4'hF;
    bit          back = 0;
    opcode = v.op;
    zero   = v.z;
    exp_q.push_back(v);
    for (int k = 0; k < 600; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (state == 4'd0) begin
          back = 1;
          break;
        end
      end
      if ((state == 4'd3 || state == 4'd5) && waited < v.stall) begin
        mem_ready = 1'b0;
        waited++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      if (state != last && n < 8) begin
        seq  = seq | (32'(state) << (4 * n));
        n++;
        last = state;
      end
      regw += int'(reg_write);
      pcen += int'(pc_en);
      we   += int'(mem_we);
      req  += int'(mem_req);
      ill  += int'(illegal_op);
      done += int'(instr_done);
      tmo  += int'(mem_timeout);
      if (state == 4'd6) chk({v.name, " execute alu_op"}, int'(alu_op), 2);
      if (state == 4'd4) chk({v.name, " mem_wb mem_to_reg"}, int'(mem_to_reg), 1);
      if (state == 4'd8) begin
        chk({v.name, " branch alu_op"}, int'(alu_op), 1);
        chk({v.name, " branch pc_src"}, int'(pc_src), 1);
        chk({v.name, " branch pc_en"}, int'(pc_en), int'(v.z));
      end
      cyc++;
    end
    chk({v.name, " returned to fetch"}, int'(back), 1);
    e = exp_q.pop_front();
    chk({e.name, " cycles"}, cyc, e.cycles);
    chk({e.name, " state seq"}, int'(seq), int'(e.seq));
    chk({e.name, " state seq len"}, n, e.seqn);
    chk({e.name, " reg_write cycles"}, regw, e.regw);
    chk({e.name, " pc_en cycles"}, pcen, e.pcen);
    chk({e.name, " mem_we cycles"}, we, e.we);
    chk({e.name, " mem_req cycles"}, req, e.req);
    chk({e.name, " illegal_op pulses"}, ill, e.ill);
    chk({e.name, " instr_done pulses"}, done, e.done);
    chk({e.name, " mem_timeout pulses"}, tmo, e.tmo);
  endtask

  function automatic vec_t mk(input string name, input logic [6:0] op, input logic z,
                              input int stall, input int cycles, input logic [31:0] seq,
                              input int seqn, input int regw, input int pcen, input int we,
                              input int req, input int ill, input int done, input int tmo);
    vec_t v;
    v.name = name; v.op = op; v.z = z; v.stall = stall; v.cycles = cycles;
    v.seq = seq; v.seqn = seqn; v.regw = regw; v.pcen = pcen; v.we = we;
    v.req = req; v.ill = ill; v.done = done; v.tmo = tmo;
    return v;
  endfunction

  initial begin
    int   hits;
    logic [20:0] outs;

    //            name        opcode       z  stl cyc seq          n  rw pe we rq il dn to
    vecs.push_back(mk("rtype",  7'b0110011, 0, 0, 4,  32'h7610,   4, 1, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk("lw0",    7'b0000011, 0, 0, 5,  32'h43210,  5, 1, 1, 0, 2, 0, 1, 0));
    vecs.push_back(mk("lw3",    7'b0000011, 0, 3, 8,  32'h43210,  5, 1, 1, 0, 5, 0, 1, 0));
    vecs.push_back(mk("sw0",    7'b0100011, 0, 0, 4,  32'h5210,   4, 0, 1, 1, 2, 0, 1, 0));
    vecs.push_back(mk("sw3",    7'b0100011, 1, 3, 7,  32'h5210,   4, 0, 1, 4, 5, 0, 1, 0));
    vecs.push_back(mk("sw6",    7'b0100011, 0, 6, 10, 32'h5210,   4, 0, 1, 7, 8, 0, 1, 1));
    vecs.push_back(mk("beq_t",  7'b1100011, 1, 0, 3,  32'h810,    3, 0, 2, 0, 1, 0, 1, 0));
    vecs.push_back(mk("beq_nt", 7'b1100011, 0, 0, 3,  32'h810,    3, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk("ill_7f", 7'b1111111, 0, 0, 2,  32'h10,     2, 0, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk("ill_00", 7'b0000000, 1, 0, 2,  32'h10,     2, 0, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk("rtype2", 7'b0110011, 1, 0, 4,  32'h7610,   4, 1, 1, 0, 1, 0, 1, 0));

    rst = 1'b1; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    outs = {mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b, alu_op,
            reg_write, mem_to_reg, instr_done, illegal_op, mem_timeout, state};
    chk("outputs during reset", int'(outs), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("state after reset", int'(state), 0);
    chk("mem_req after reset", int'(mem_req), 1);

    foreach (vecs[i]) run(vecs[i]);

    // Reset while lw is stalled in MEM_READ
    opcode = 7'b0000011;
    hits = 0;
    for (int k = 0; k < 20 && hits < 2; k++) begin
      @(negedge clk);
      if (state == 4'd3) hits++;
      mem_ready = (state == 4'd3) ? 1'b0 : 1'b1;
    end
    chk("reached mem_read stall", hits, 2);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    outs = {mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b, alu_op,
            reg_write, mem_to_reg, instr_done, illegal_op, mem_timeout, state};
    chk("outputs during mid-read reset", int'(outs), 0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("state after mid-read reset", int'(state), 0);
    chk("mem_req after mid-read reset", int'(mem_req), 1);
    chk("iord after mid-read reset", int'(iord), 0);
    chk("ir_write while fetch stalled", int'(ir_write), 0);
    @(negedge clk);
    #1;
    chk("fetch holds while not ready", int'(state), 0);
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("decode after fetch completes", int'(state), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
